aes_sbsr_pipe: RTL and testbench



---
 rtl/aes_pkg.sv | 65 ++++++
 rtl/aes_sbox.sv | 21 ++
 rtl/aes_sbsr_pipe.sv | 133 +++++++++++++
 tb/tb_aes_sbsr_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants for the SubBytes/ShiftRows engine.
// Contains the forward/inverse S-box tables, the row permutations, the FSM states and the mode encodings.
package aes_pkg;

   localparam logic AES_MODE_ENC = 1'b0;
   localparam logic AES_MODE_DEC = 1'b1;

   typedef enum logic [1:0] {IDLE, SUB, OUT} state_e;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // Byte k of the state lives at [127-8k -: 8]; s[r,c] is byte r+4c.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      return o;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES S-box, combinational, zero latency, no handshake.
// The inverse table is only built when INV_EN is set; otherwise mode is ignored.
module aes_sbox
   import aes_pkg::*;
#(
   parameter bit INV_EN = 1'b1
) (
   input  logic [7:0] in_byte,
   input  logic       mode,
   output logic [7:0] out_byte
);

   if (INV_EN) begin : g_inv
      always_comb out_byte = (mode == AES_MODE_DEC) ? INV_SBOX[in_byte] : SBOX[in_byte];
   end else begin : g_fwd
      logic unused_mode;
      assign unused_mode = mode;
      always_comb out_byte = SBOX[in_byte];
   end

endmodule

// File: rtl/aes_sbsr_pipe.sv
// Folded (Inv)SubBytes+(Inv)ShiftRows: result valid N=16/SBOX_LANES edges after accept.
// Valid/ready both sides; a held result stalls intake, which resumes on the same edge the result drains.
module aes_sbsr_pipe
   import aes_pkg::*;
#(
   parameter int SBOX_LANES = 16,
   parameter bit INV_EN     = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_mode,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         out_mode,
   output logic         busy
);

   localparam int N  = 16 / SBOX_LANES;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (!(SBOX_LANES inside {1, 2, 4, 8, 16})) begin : g_bad_lanes
      $error("aes_sbsr_pipe: SBOX_LANES must be 1, 2, 4, 8 or 16");
   end

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [127:0]    work_q, work_d;
   logic            mode_q, mode_d;
   logic            out_valid_q, out_valid_d;
   logic [127:0]    out_data_q, out_data_d;
   logic            out_mode_q, out_mode_d;

   logic [7:0]      sb_in  [SBOX_LANES];
   logic [7:0]      sb_out [SBOX_LANES];
   logic [127:0]    sub_state;

   for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
      aes_sbox #(.INV_EN(INV_EN)) u_sbox (
         .in_byte  (sb_in[l]),
         .mode     (mode_q),
         .out_byte (sb_out[l])
      );
   end

   // Lane l handles byte cnt*SBOX_LANES+l of the working state this cycle.
   always_comb begin
      for (int l = 0; l < SBOX_LANES; l++) sb_in[l] = '0;
      for (int k = 0; k < 16; k++)
         if (CW'(k / SBOX_LANES) == cnt_q) sb_in[k % SBOX_LANES] = work_q[127-8*k -: 8];
   end

   always_comb begin
      sub_state = work_q;
      for (int k = 0; k < 16; k++)
         if (CW'(k / SBOX_LANES) == cnt_q) sub_state[127-8*k -: 8] = sb_out[k % SBOX_LANES];
   end

   assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == OUT) && out_ready));
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_mode  = out_mode_q;
   assign busy      = (state_q == SUB) || (state_q == OUT);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      work_d      = work_q;
      mode_d      = mode_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_mode_d  = out_mode_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d  = in_data;
               mode_d  = INV_EN ? in_mode : AES_MODE_ENC;
               cnt_d   = '0;
               state_d = SUB;
            end
         end
         SUB: begin
            work_d = sub_state;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
               out_data_d  = (mode_q == AES_MODE_DEC) ? inv_shift_rows(sub_state) : shift_rows(sub_state);
               out_mode_d  = mode_q;
               out_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = OUT;
            end
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (in_valid) begin
                  work_d  = in_data;
                  mode_d  = INV_EN ? in_mode : AES_MODE_ENC;
                  cnt_d   = '0;
                  state_d = SUB;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         work_q      <= '0;
         mode_q      <= AES_MODE_ENC;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_mode_q  <= AES_MODE_ENC;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         work_q      <= work_d;
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_mode_q  <= out_mode_d;
      end
   end

endmodule

// File: tb/tb_aes_sbsr_pipe.sv
// Bench for aes_sbsr_pipe: four instances (16/4/1 lanes with inverse, 8 lanes forward-only)
// driven from a known-answer table plus backpressure and mid-operation reset sequences.
`timescale 1ns/1ps
module tb_aes_sbsr_pipe;

   localparam int NDUT = 4;

   localparam logic [127:0] V_IN   = 128'h00102030405060708090a0b0c0d0e0f0;
   localparam logic [127:0] V_OUT  = 128'h6353e08c0960e104cd70b751bacad0e7;
   localparam logic [127:0] F_IN   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] F_OUT  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] ZERO   = 128'h0;
   localparam logic [127:0] ALL_63 = {16{8'h63}};
   localparam logic [127:0] ALL_52 = {16{8'h52}};

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid  [NDUT];
   logic         in_ready  [NDUT];
   logic         in_mode   [NDUT];
   logic [127:0] in_data   [NDUT];
   logic         out_valid [NDUT];
   logic         out_ready [NDUT];
   logic [127:0] out_data  [NDUT];
   logic         out_mode  [NDUT];
   logic         busy      [NDUT];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      aes_sbsr_pipe #(
         .SBOX_LANES ((g == 0) ? 16 : (g == 1) ? 4 : (g == 2) ? 1 : 8),
         .INV_EN     (g != 3)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_mode   (in_mode[g]),
         .in_data   (in_data[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_data  (out_data[g]),
         .out_mode  (out_mode[g]),
         .busy      (busy[g])
      );
   end

   function automatic int lanes_of(input int d);
      case (d)
         0: return 16;
         1: return 4;
         2: return 1;
         default: return 8;
      endcase
   endfunction

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   typedef struct {
      int           dut;
      logic [127:0] data;
      logic         mode;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   // Scoreboard: every completed output handshake pops one expectation.
   always @(negedge clk) begin
      for (int d = 0; d < NDUT; d++) begin
         if (out_valid[d] && out_ready[d]) begin
            if (sb_q.size() == 0) begin
               check($sformatf("unexpected_out_dut%0d", d), 128'(out_valid[d]), 128'd0);
            end else begin
               mon_e = sb_q.pop_front();
               check($sformatf("sb_dut_id_%0d", d), 128'(d), 128'(mon_e.dut));
               check($sformatf("sb_data_dut%0d", d), out_data[d], mon_e.data);
               check($sformatf("sb_mode_dut%0d", d), 128'(out_mode[d]), 128'(mon_e.mode));
            end
         end
      end
   end

   // Present a block until accepted; returns just after the accept edge.
   task automatic send(input int d, input logic mode, input logic [127:0] din,
                       input logic [127:0] exp_d, input logic exp_m, input bit push);
      bit acc;
      exp_t e;
      acc = 1'b0;
      in_valid[d] = 1'b1;
      in_mode[d]  = mode;
      in_data[d]  = din;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         if (in_ready[d]) acc = 1'b1;
         @(posedge clk);
         #1;
      end
      check($sformatf("accept_dut%0d", d), 128'(acc), 128'd1);
      if (acc && push) begin
         e.dut = d; e.data = exp_d; e.mode = exp_m;
         sb_q.push_back(e);
      end
      in_valid[d] = 1'b0;
      in_mode[d]  = ~mode;
      in_data[d]  = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Counts SUB cycles until out_valid; engine must be busy and not ready meanwhile.
   task automatic wait_out(input int d, input int exp_lat, input string tag);
      bit seen;
      bit sub_ok;
      int k;
      seen = 1'b0; sub_ok = 1'b1; k = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (out_valid[d]) seen = 1'b1;
         else begin
            k++;
            if (in_ready[d] !== 1'b0 || busy[d] !== 1'b1) sub_ok = 1'b0;
         end
      end
      check({tag, "_seen"}, 128'(seen), 128'd1);
      check({tag, "_latency"}, 128'(k), 128'(exp_lat));
      check({tag, "_sub_busy"}, 128'(sub_ok), 128'd1);
   endtask

   typedef struct {
      int           dut;
      logic         mode;
      logic [127:0] din;
      logic [127:0] dout;
      logic         omode;
   } vec_t;

   vec_t tbl [11];

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] held;
      bit           stable;
      bit           rdy_ok;
      bit           quiet;

      tbl[0]  = '{0, 1'b0, V_IN,  V_OUT,  1'b0};
      tbl[1]  = '{0, 1'b1, V_OUT, V_IN,   1'b1};
      tbl[2]  = '{0, 1'b0, F_IN,  F_OUT,  1'b0};
      tbl[3]  = '{0, 1'b1, F_OUT, F_IN,   1'b1};
      tbl[4]  = '{1, 1'b0, V_IN,  V_OUT,  1'b0};
      tbl[5]  = '{1, 1'b0, ZERO,  ALL_63, 1'b0};
      tbl[6]  = '{1, 1'b1, ZERO,  ALL_52, 1'b1};
      tbl[7]  = '{1, 1'b1, F_OUT, F_IN,   1'b1};
      tbl[8]  = '{2, 1'b1, V_OUT, V_IN,   1'b1};
      tbl[9]  = '{3, 1'b1, V_IN,  V_OUT,  1'b0};
      tbl[10] = '{3, 1'b0, F_IN,  F_OUT,  1'b0};

      rst = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
         in_valid[d] = 1'b0; in_mode[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b1;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("in_ready_in_reset", 128'(in_ready[0]), 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("rst_out_valid_%0d", d), 128'(out_valid[d]), 128'd0);
         check($sformatf("rst_in_ready_%0d", d),  128'(in_ready[d]),  128'd1);
         check($sformatf("rst_busy_%0d", d),      128'(busy[d]),      128'd0);
         check($sformatf("rst_out_data_%0d", d),  out_data[d],        128'd0);
         check($sformatf("rst_out_mode_%0d", d),  128'(out_mode[d]),  128'd0);
      end
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) begin
         send(tbl[i].dut, tbl[i].mode, tbl[i].din, tbl[i].dout, tbl[i].omode, 1'b1);
         wait_out(tbl[i].dut, 16 / lanes_of(tbl[i].dut), $sformatf("vec%0d", i));
         @(posedge clk); #1;
      end

      // Backpressure: result held for 5 cycles, then drain and accept on one edge.
      out_ready[0] = 1'b0;
      send(0, 1'b0, V_IN, V_OUT, 1'b0, 1'b1);
      wait_out(0, 1, "bp_a");
      held = out_data[0];
      stable = 1'b1; rdy_ok = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (out_data[0] !== held || out_valid[0] !== 1'b1) stable = 1'b0;
         if (in_ready[0] !== 1'b0) rdy_ok = 1'b0;
      end
      check("bp_hold_stable", 128'(stable), 128'd1);
      check("bp_hold_in_ready_low", 128'(rdy_ok), 128'd1);
      check("bp_held_value", held, V_OUT);
      @(posedge clk); #1;
      out_ready[0] = 1'b1;
      in_valid[0] = 1'b1; in_mode[0] = 1'b1; in_data[0] = F_OUT;
      sb_q.push_back('{0, F_IN, 1'b1});
      @(negedge clk);
      check("bp_same_edge_ready", 128'(in_ready[0]), 128'd1);
      @(posedge clk); #1;
      in_valid[0] = 1'b0; in_data[0] = '0;
      wait_out(0, 1, "bp_b");
      @(posedge clk); #1;

      // Mid-operation reset on the single-lane engine: block is dropped.
      send(2, 1'b0, F_IN, F_OUT, 1'b0, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("midrst_in_ready_low", 128'(in_ready[2]), 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", 128'(out_valid[2]), 128'd0);
      check("midrst_in_ready",  128'(in_ready[2]),  128'd1);
      check("midrst_busy",      128'(busy[2]),      128'd0);
      check("midrst_out_data",  out_data[2],        128'd0);
      check("midrst_out_mode",  128'(out_mode[2]),  128'd0);
      quiet = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (out_valid[2] !== 1'b0) quiet = 1'b0;
      end
      check("midrst_no_output", 128'(quiet), 128'd1);
      @(posedge clk); #1;
      send(2, 1'b0, V_IN, V_OUT, 1'b0, 1'b1);
      wait_out(2, 16, "post_rst");
      @(posedge clk); #1;

      repeat (4) @(posedge clk);
      @(negedge clk);
      check("scoreboard_drained", 128'(sb_q.size()), 128'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
